// File: rtl/vote_session_ctrl.sv
// Voting-booth sequencer: arms once per voter, accepts one vote by fixed priority, then locks out.
// Latency: a vote pulse in cycle N is acknowledged and tallied at edge N+1; result readout lags result_sel by 1 cycle.
// Backpressure: none; presses outside ARMED and losing simultaneous presses are dropped, never queued.
module vote_session_ctrl #(
  parameter int NUM_CAND       = 4,
  parameter int CNT_W          = 8,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter int SEL_W          = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                voter_enable,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic [SEL_W-1:0]    result_sel,
  output logic                ready,
  output logic [NUM_CAND-1:0] vote_ack,
  output logic                multi_press,
  output logic [CNT_W-1:0]    result_count,
  output logic [CNT_W-1:0]    total_votes,
  output logic                sat
);

  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT, RESULT} state_t;

  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic [CNT_W-1:0]    tally_q [NUM_CAND];
  logic [CNT_W-1:0]    total_q;
  logic                sat_q;
  logic                ready_q, ready_d;
  logic [NUM_CAND-1:0] ack_q, ack_d;
  logic                multi_q, multi_d;
  logic [CNT_W-1:0]    rc_q, rc_d;

  logic                any_vote;
  logic                accept;
  logic                multi;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_CAND-1:0] win_onehot;
  logic                sel_ok;

  // Fixed-priority winner: lowest set index; detect more than one simultaneous press.
  always_comb begin
    any_vote = |valid_vote;
    win_idx  = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (valid_vote[i]) win_idx = IDX_W'(i);
    end
    win_onehot = NUM_CAND'(1) << win_idx;
    multi      = |(valid_vote & (valid_vote - NUM_CAND'(1)));
  end

  // Next state, lockout countdown and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mode)              state_d = RESULT;
        else if (voter_enable) state_d = ARMED;
      end
      ARMED: begin
        // A press beats a simultaneous switch to readout mode.
        if (any_vote) begin
          accept  = 1'b1;
          state_d = LOCKOUT;
          lock_d  = LOCK_W'(LOCKOUT_CYCLES - 1);
        end else if (mode) begin
          state_d = RESULT;
        end
      end
      LOCKOUT: begin
        if (lock_q == '0) state_d = IDLE;
        else              lock_d  = lock_q - LOCK_W'(1);
      end
      RESULT: begin
        if (!mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sel_ok  = (int'(result_sel) < NUM_CAND);
    ready_d = (state_d == ARMED);
    ack_d   = accept ? win_onehot : '0;
    multi_d = accept & multi;
    rc_d    = '0;
    if (state_d == RESULT && sel_ok) rc_d = tally_q[IDX_W'(result_sel)];
  end

  // State, lockout counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ready_q <= 1'b0;
      ack_q   <= '0;
      multi_q <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      multi_q <= multi_d;
      rc_q    <= rc_d;
    end
  end

  // Saturating tallies; a dropped increment raises the sticky sat flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      sat_q   <= 1'b0;
    end else if (accept) begin
      if (tally_q[win_idx] == CNT_MAX) sat_q <= 1'b1;
      else                             tally_q[win_idx] <= tally_q[win_idx] + CNT_W'(1);
      if (total_q == CNT_MAX) sat_q <= 1'b1;
      else                    total_q <= total_q + CNT_W'(1);
    end
  end

  assign ready        = ready_q;
  assign vote_ack     = ack_q;
  assign multi_press  = multi_q;
  assign result_count = rc_q;
  assign total_votes  = total_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: main instance (CNT_W=8) plus a narrow instance (CNT_W=2) for saturation.
// Acks are matched against a queue of expected {multi_press, vote_ack} pushed when votes are driven.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
module tb_vote_session_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0, voter_enable = 1'b0;
  logic [3:0] valid_vote = '0;
  logic [1:0] result_sel = '0;
  logic       ready, multi_press, sat;
  logic [3:0] vote_ack;
  logic [7:0] result_count, total_votes;

  logic       b_mode = 1'b0, b_en = 1'b0;
  logic [3:0] b_vote = '0;
  logic [1:0] b_sel = '0;
  logic       b_ready, b_multi, b_sat;
  logic [3:0] b_ack;
  logic [1:0] b_rc, b_total;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  int exp_tally[4];
  int exp_total;

  vote_session_ctrl #(.NUM_CAND(4), .CNT_W(8), .LOCKOUT_CYCLES(4), .SEL_W(2)) dut (
    .clock(clock), .reset(reset), .mode(mode), .voter_enable(voter_enable),
    .valid_vote(valid_vote), .result_sel(result_sel), .ready(ready), .vote_ack(vote_ack),
    .multi_press(multi_press), .result_count(result_count), .total_votes(total_votes), .sat(sat));

  vote_session_ctrl #(.NUM_CAND(4), .CNT_W(2), .LOCKOUT_CYCLES(4), .SEL_W(2)) dut_narrow (
    .clock(clock), .reset(reset), .mode(b_mode), .voter_enable(b_en),
    .valid_vote(b_vote), .result_sel(b_sel), .ready(b_ready), .vote_ack(b_ack),
    .multi_press(b_multi), .result_count(b_rc), .total_votes(b_total), .sat(b_sat));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Scoreboard: every ack pulse of the main instance must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && vote_ack !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack got ack=%b mp=%b expected no ack", vote_ack, multi_press);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({multi_press, vote_ack} !== e) begin
          errors++;
          $display("FAIL sb_ack got mp=%b ack=%b expected mp=%b ack=%b",
                   multi_press, vote_ack, e[4], e[3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) exp_tally[i] = 0;
    exp_total = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    tick();
  endtask

  // One full session from IDLE; returns in IDLE after the lockout has expired.
  task automatic cast_vote(input logic [3:0] v, input int win, input logic mp);
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    valid_vote = v;
    exp_q.push_back({mp, 4'(1 << win)});
    exp_tally[win]++;
    exp_total++;
    tick();
    valid_vote = '0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ready, vote_ack, multi_press, sat} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got ready=%b ack=%b mp=%b sat=%b expected all 0", ready, vote_ack, multi_press, sat);
    end
    reset = 1'b0;
    clear_model();
    tick();
    checks++;
    if (total_votes !== 8'd0 || result_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts got total=%0d rc=%0d expected 0 0", total_votes, result_count);
    end
    checks++;
    if ({b_ready, b_ack, b_multi, b_sat, b_rc, b_total} !== 11'b0) begin
      errors++;
      $display("FAIL reset_narrow got ready=%b ack=%b sat=%b total=%0d expected all 0", b_ready, b_ack, b_sat, b_total);
    end
  endtask

  task automatic test_single_vote();
    int n;
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_enable got %b expected 1", ready); end
    tick();
    valid_vote = 4'b0100;
    exp_q.push_back({1'b0, 4'b0100});
    exp_tally[2]++; exp_total++;
    tick();
    valid_vote = '0;
    checks++;
    if (vote_ack !== 4'b0100 || ready !== 1'b0) begin
      errors++; $display("FAIL single_ack got ack=%b ready=%b expected 0100 0", vote_ack, ready);
    end
    checks++;
    if (total_votes !== 8'(exp_total)) begin
      errors++; $display("FAIL single_total got %0d expected %0d", total_votes, exp_total);
    end
    // Hold enable through lockout: it is only honoured once IDLE is reached.
    voter_enable = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    voter_enable = 1'b0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL lockout_length got %0d cycles to re-arm expected 5", n); end
  endtask

  task automatic test_multi_press();
    valid_vote = 4'b1010;
    exp_q.push_back({1'b1, 4'b0010});
    exp_tally[1]++; exp_total++;
    tick();
    valid_vote = '0;
    checks++;
    if (vote_ack !== 4'b0010 || multi_press !== 1'b1) begin
      errors++; $display("FAIL multi_ack got ack=%b mp=%b expected 0010 1", vote_ack, multi_press);
    end
    checks++;
    if (total_votes !== 8'(exp_total)) begin
      errors++; $display("FAIL multi_total got %0d expected %0d", total_votes, exp_total);
    end
  endtask

  task automatic test_lockout_ignore();
    valid_vote = 4'b0001;
    voter_enable = 1'b1;
    tick();
    valid_vote = '0;
    voter_enable = 1'b0;
    checks++;
    if (vote_ack !== 4'b0000 || ready !== 1'b0) begin
      errors++; $display("FAIL lockout_press got ack=%b ready=%b expected 0000 0", vote_ack, ready);
    end
    repeat (8) tick();
    checks++;
    if (ready !== 1'b0 || total_votes !== 8'(exp_total)) begin
      errors++; $display("FAIL lockout_after got ready=%b total=%0d expected 0 %0d", ready, total_votes, exp_total);
    end
    mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      result_sel = 2'(s);
      tick();
      checks++;
      if (result_count !== 8'(exp_tally[s])) begin
        errors++; $display("FAIL tally_after_multi sel=%0d got %0d expected %0d", s, result_count, exp_tally[s]);
      end
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_result();
    do_reset();
    cast_vote(4'b1000, 3, 1'b0);
    cast_vote(4'b0010, 1, 1'b0);
    cast_vote(4'b0010, 1, 1'b0);
    checks++;
    if (total_votes !== 8'd3) begin errors++; $display("FAIL result_total got %0d expected 3", total_votes); end
    mode = 1'b1;
    result_sel = 2'd1;
    tick();
    checks++;
    if (result_count !== 8'd2) begin errors++; $display("FAIL result_sel1 got %0d expected 2", result_count); end
    result_sel = 2'd3;
    tick();
    checks++;
    if (result_count !== 8'd1) begin errors++; $display("FAIL result_sel3 got %0d expected 1", result_count); end
    result_sel = 2'd0;
    tick();
    checks++;
    if (result_count !== 8'd0) begin errors++; $display("FAIL result_sel0 got %0d expected 0", result_count); end
    valid_vote = 4'b1111;
    voter_enable = 1'b1;
    tick();
    valid_vote = '0;
    voter_enable = 1'b0;
    tick();
    checks++;
    if (total_votes !== 8'd3 || ready !== 1'b0) begin
      errors++; $display("FAIL result_ignore got total=%0d ready=%b expected 3 0", total_votes, ready);
    end
    result_sel = 2'd1;
    tick();
    checks++;
    if (result_count !== 8'd2) begin errors++; $display("FAIL result_unchanged got %0d expected 2", result_count); end
    mode = 1'b0;
    tick();
    checks++;
    if (result_count !== 8'd0) begin errors++; $display("FAIL result_exit got %0d expected 0", result_count); end
    cast_vote(4'b0100, 2, 1'b0);
    checks++;
    if (total_votes !== 8'(exp_total)) begin errors++; $display("FAIL result_revote got %0d expected %0d", total_votes, exp_total); end
  endtask

  task automatic test_mode_priority();
    mode = 1'b1;
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    result_sel = 2'd3;
    tick();
    checks++;
    if (ready !== 1'b0 || result_count !== 8'(exp_tally[3])) begin
      errors++; $display("FAIL idle_mode_prio got ready=%b rc=%0d expected 0 %0d", ready, result_count, exp_tally[3]);
    end
    mode = 1'b0;
    tick();
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    mode = 1'b1;
    valid_vote = 4'b0001;
    exp_q.push_back({1'b0, 4'b0001});
    exp_tally[0]++; exp_total++;
    tick();
    valid_vote = '0;
    checks++;
    if (vote_ack !== 4'b0001 || total_votes !== 8'(exp_total)) begin
      errors++; $display("FAIL vote_beats_mode got ack=%b total=%0d expected 0001 %0d", vote_ack, total_votes, exp_total);
    end
    repeat (6) tick();
    result_sel = 2'd0;
    tick();
    checks++;
    if (result_count !== 8'(exp_tally[0])) begin
      errors++; $display("FAIL mode_after_lockout got %0d expected %0d", result_count, exp_tally[0]);
    end
    mode = 1'b0;
    tick();
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    mode = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b0 || total_votes !== 8'(exp_total)) begin
      errors++; $display("FAIL cancel_session got ready=%b total=%0d expected 0 %0d", ready, total_votes, exp_total);
    end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      b_en = 1'b1;
      tick();
      b_en = 1'b0;
      b_vote = 4'b0001;
      tick();
      b_vote = '0;
      checks++;
      if (b_ack !== 4'b0001) begin errors++; $display("FAIL sat_ack%0d got %b expected 0001", k, b_ack); end
      checks++;
      if (b_sat !== (k == 3) || b_total !== 2'((k < 3) ? k + 1 : 3)) begin
        errors++; $display("FAIL sat_state%0d got sat=%b total=%0d expected %0d %0d", k, b_sat, b_total, (k == 3), (k < 3) ? k + 1 : 3);
      end
      repeat (5) tick();
    end
    b_mode = 1'b1;
    b_sel = 2'd0;
    tick();
    checks++;
    if (b_rc !== 2'd3 || b_sat !== 1'b1) begin
      errors++; $display("FAIL sat_tally got rc=%0d sat=%b expected 3 1", b_rc, b_sat);
    end
    b_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_session();
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    valid_vote = 4'b0010;
    exp_q.push_back({1'b0, 4'b0010});
    tick();
    valid_vote = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    checks++;
    if (ready !== 1'b0 || total_votes !== 8'd0 || sat !== 1'b0 || vote_ack !== 4'b0000) begin
      errors++; $display("FAIL midreset_out got ready=%b total=%0d sat=%b ack=%b expected 0 0 0 0000", ready, total_votes, sat, vote_ack);
    end
    checks++;
    if (b_sat !== 1'b0 || b_total !== 2'd0) begin
      errors++; $display("FAIL midreset_narrow got sat=%b total=%0d expected 0 0", b_sat, b_total);
    end
    mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      result_sel = 2'(s);
      tick();
      checks++;
      if (result_count !== 8'd0) begin errors++; $display("FAIL midreset_tally sel=%0d got %0d expected 0", s, result_count); end
    end
    mode = 1'b0;
    tick();
    voter_enable = 1'b1;
    tick();
    voter_enable = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_rearm got ready=%b expected 1", ready); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single_vote();
    test_multi_press();
    test_lockout_ignore();
    test_result();
    test_mode_priority();
    test_saturation();
    test_reset_mid_session();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending acks expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
